// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline boundary: two-entry head/skid buffer with a registered ex_ready,
// and a bypass port that exports the youngest buffered GPR write.
module ex_mem_pipe #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FUNCT_W    = 6,
  parameter int MEM_OP_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [PC_W-1:0]       ex_pc,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic [FUNCT_W-1:0]    ex_funct,
  input  logic                  ex_wen,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [MEM_OP_W-1:0]   ex_mem_op,
  input  logic [DATA_W-1:0]     ex_mem_wdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [PC_W-1:0]       mem_pc,
  output logic [DATA_W-1:0]     mem_result,
  output logic [FUNCT_W-1:0]    mem_funct,
  output logic                  mem_wen,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic [MEM_OP_W-1:0]   mem_mem_op,
  output logic [DATA_W-1:0]     mem_mem_wdata,
  output logic                  fwd_en,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  fwd_is_load,
  output logic [1:0]            occupancy
);

  // Encoding equals the entry count, so occupancy is the state register itself.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [DATA_W-1:0]     result;
    logic [FUNCT_W-1:0]    funct;
    logic                  wen;
    logic [REG_ADDR_W-1:0] waddr;
    logic [MEM_OP_W-1:0]   mem_op;
    logic [DATA_W-1:0]     wdata;
  } entry_t;

  logic [1:0] r_state;
  logic       r_ex_ready;
  entry_t     r_head;
  entry_t     r_skid;

  logic [1:0] w_state_nxt;
  logic       w_accept;
  logic       w_deq;
  logic       w_load_head;
  logic       w_load_skid;
  logic       w_skid_to_head;
  entry_t     w_in;

  logic                  w_src_valid;
  logic                  w_src_wen;
  logic                  w_src_load;
  logic [REG_ADDR_W-1:0] w_src_waddr;
  logic [DATA_W-1:0]     w_src_result;

  always_comb begin
    w_in.pc     = ex_pc;
    w_in.result = ex_result;
    w_in.funct  = ex_funct;
    // A write to r0 is architecturally a no-op, so it is stored as non-writing.
    w_in.wen    = ex_wen & (|ex_waddr);
    w_in.waddr  = ex_waddr;
    w_in.mem_op = ex_mem_op;
    w_in.wdata  = ex_mem_wdata;
  end

  assign w_accept = ex_valid & r_ex_ready;
  assign w_deq    = (r_state != EMPTY) & mem_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_head    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_head = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_load_head = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_accept && w_deq) begin
          w_load_head = 1'b1;
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = TWO;
        end else if (w_deq) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_deq) begin
          w_skid_to_head = 1'b1;
          w_state_nxt    = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) w_state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= EMPTY;
      r_ex_ready <= 1'b1;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ex_ready <= (w_state_nxt != TWO);
      if (w_load_head)         r_head <= w_in;
      else if (w_skid_to_head) r_head <= r_skid;
      if (w_load_skid)         r_skid <= w_in;
    end
  end

  assign ex_ready  = r_ex_ready;
  assign occupancy = r_state;
  assign mem_valid = (r_state != EMPTY);

  always_comb begin
    mem_pc        = '0;
    mem_result    = '0;
    mem_funct     = '0;
    mem_wen       = 1'b0;
    mem_waddr     = '0;
    mem_mem_op    = '0;
    mem_mem_wdata = '0;
    if (mem_valid) begin
      mem_pc        = r_head.pc;
      mem_result    = r_head.result;
      mem_funct     = r_head.funct;
      mem_wen       = r_head.wen;
      mem_waddr     = r_head.waddr;
      mem_mem_op    = r_head.mem_op;
      mem_mem_wdata = r_head.wdata;
    end
  end

  // Youngest in-flight entry is the skid when both slots are full.
  assign w_src_valid  = (r_state != EMPTY);
  assign w_src_wen    = (r_state == TWO) ? r_skid.wen       : r_head.wen;
  assign w_src_load   = (r_state == TWO) ? r_skid.mem_op[3] : r_head.mem_op[3];
  assign w_src_waddr  = (r_state == TWO) ? r_skid.waddr     : r_head.waddr;
  assign w_src_result = (r_state == TWO) ? r_skid.result    : r_head.result;

  assign fwd_en      = w_src_valid & w_src_wen;
  assign fwd_is_load = w_src_valid & w_src_load;
  assign fwd_addr    = fwd_en ? w_src_waddr  : '0;
  assign fwd_data    = fwd_en ? w_src_result : '0;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: expected entries queued on accept, compared at the head.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_result = '0;
  logic [5:0]  ex_funct = '0;
  logic        ex_wen = 1'b0;
  logic [4:0]  ex_waddr = '0;
  logic [3:0]  ex_mem_op = '0;
  logic [31:0] ex_mem_wdata = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_pc;
  logic [31:0] mem_result;
  logic [5:0]  mem_funct;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [3:0]  mem_mem_op;
  logic [31:0] mem_mem_wdata;
  logic        fwd_en;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        fwd_is_load;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [5:0]  funct;
    logic        wen;
    logic [4:0]  waddr;
    logic [3:0]  mem_op;
    logic [31:0] wdata;
  } ent_t;

  ent_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ex_mem_pipe #(.DATA_W(32), .PC_W(32), .REG_ADDR_W(5), .FUNCT_W(6), .MEM_OP_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_funct(ex_funct), .ex_wen(ex_wen),
    .ex_waddr(ex_waddr), .ex_mem_op(ex_mem_op), .ex_mem_wdata(ex_mem_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc), .mem_result(mem_result),
    .mem_funct(mem_funct), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_mem_op(mem_mem_op),
    .mem_mem_wdata(mem_mem_wdata), .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .fwd_is_load(fwd_is_load), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] res,
                              input logic wen, input logic [4:0] wa, input logic [3:0] op);
    ent_t e;
    e.pc = pc; e.result = res; e.funct = pc[7:2]; e.wen = wen;
    e.waddr = wa; e.mem_op = op; e.wdata = ~pc;
    return e;
  endfunction

  task automatic offer(input logic v, input ent_t e);
    ex_valid = v; ex_pc = e.pc; ex_result = e.result; ex_funct = e.funct; ex_wen = e.wen;
    ex_waddr = e.waddr; ex_mem_op = e.mem_op; ex_mem_wdata = e.wdata;
  endtask

  // Advance one clock and update the reference queue from the inputs just driven.
  task automatic tick();
    bit   acc, deq;
    ent_t e;
    acc = ex_valid && (sb.size() < 2);
    deq = mem_ready && (sb.size() > 0);
    e = mk(ex_pc, ex_result, ex_wen && (ex_waddr != 5'd0), ex_waddr, ex_mem_op);
    e.funct = ex_funct; e.wdata = ex_mem_wdata;
    @(posedge clk); #1;
    if (flush) sb.delete();
    else begin
      if (deq) void'(sb.pop_front());
      if (acc) sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
    n_tests++;
    if ({mem_valid, occupancy, fwd_en, fwd_is_load, mem_pc, mem_result} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got v=%b occ=%0d fwd=%b pc=%h exp all 0",
                         mem_valid, occupancy, fwd_en, mem_pc);
    end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    ent_t h;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, mk(32'h100 + 32'(4*i), 32'h101 + 32'(4*i), 1'b1, 5'(i+1), 4'h0));
      n_tests++;
      if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, ex_ready); end
      tick();
      h = (sb.size() > 0) ? sb[0] : '0;
      n_tests++;
      if (mem_valid !== 1'b1 || occupancy !== 2'd1 || mem_pc !== h.pc || mem_result !== h.result ||
          mem_funct !== h.funct || mem_waddr !== h.waddr || mem_mem_wdata !== h.wdata) begin
        n_fail++; $display("FAIL stream_head[%0d] got v=%b occ=%0d pc=%h res=%h exp v=1 occ=1 pc=%h res=%h",
                           i, mem_valid, occupancy, mem_pc, mem_result, h.pc, h.result);
      end
    end
    offer(1'b0, '0);
    tick();
    n_tests++;
    if (mem_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", mem_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    ent_t h;
    mem_ready = 1'b0;
    offer(1'b1, mk(32'h100, 32'h101, 1'b1, 5'd1, 4'h0)); tick();
    offer(1'b1, mk(32'h104, 32'h105, 1'b1, 5'd2, 4'h0)); tick();
    offer(1'b1, mk(32'h108, 32'h109, 1'b1, 5'd3, 4'h0));
    n_tests++;
    if (ex_ready !== 1'b0 || occupancy !== 2'd2) begin
      n_fail++; $display("FAIL bp_full got rdy=%b occ=%0d exp rdy=0 occ=2", ex_ready, occupancy);
    end
    tick();
    n_tests++;
    if (occupancy !== 2'd2 || sb.size() != 2) begin
      n_fail++; $display("FAIL bp_hold got occ=%0d exp=2", occupancy);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      h = (sb.size() > 0) ? sb[0] : '0;
      n_tests++;
      if (mem_valid !== 1'b1 || mem_pc !== h.pc || mem_result !== h.result || sb.size() == 0) begin
        n_fail++; $display("FAIL bp_order[%0d] got v=%b pc=%h exp v=1 pc=%h", i, mem_valid, mem_pc, h.pc);
      end
      tick();
    end
    offer(1'b0, '0);
    tick();
    n_tests++;
    if (mem_valid !== 1'b0 || ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain got v=%b rdy=%b exp v=0 rdy=1", mem_valid, ex_ready);
    end
  endtask

  task automatic test_forward();
    mem_ready = 1'b0;
    offer(1'b1, mk(32'h400, 32'h0000_AAAA, 1'b1, 5'd3, 4'h0)); tick();
    offer(1'b1, mk(32'h404, 32'h0000_5555, 1'b1, 5'd7, 4'h8)); tick();
    offer(1'b0, '0);
    n_tests++;
    if (fwd_en !== 1'b1 || fwd_addr !== 5'd7 || fwd_data !== 32'h5555 || fwd_is_load !== 1'b1) begin
      n_fail++; $display("FAIL fwd_two got en=%b a=%0d d=%h ld=%b exp en=1 a=7 d=5555 ld=1",
                         fwd_en, fwd_addr, fwd_data, fwd_is_load);
    end
    n_tests++;
    if (mem_waddr !== 5'd3 || mem_result !== 32'hAAAA) begin
      n_fail++; $display("FAIL fwd_head got a=%0d d=%h exp a=3 d=aaaa", mem_waddr, mem_result);
    end
    mem_ready = 1'b1;
    tick();
    n_tests++;
    if (fwd_en !== 1'b1 || fwd_addr !== 5'd7 || fwd_is_load !== 1'b1 || mem_pc !== 32'h404) begin
      n_fail++; $display("FAIL fwd_one got en=%b a=%0d ld=%b pc=%h exp en=1 a=7 ld=1 pc=404",
                         fwd_en, fwd_addr, fwd_is_load, mem_pc);
    end
    tick();
    n_tests++;
    if (fwd_en !== 1'b0 || fwd_is_load !== 1'b0 || fwd_addr !== 5'd0 || fwd_data !== 32'd0) begin
      n_fail++; $display("FAIL fwd_empty got en=%b ld=%b a=%0d d=%h exp all 0", fwd_en, fwd_is_load, fwd_addr, fwd_data);
    end
  endtask

  task automatic test_zero_waddr();
    mem_ready = 1'b0;
    offer(1'b1, mk(32'h500, 32'h1234, 1'b1, 5'd0, 4'h0)); tick();
    offer(1'b0, '0);
    n_tests++;
    if (mem_valid !== 1'b1 || mem_wen !== 1'b0 || fwd_en !== 1'b0 || fwd_addr !== 5'd0 || fwd_data !== 32'd0) begin
      n_fail++; $display("FAIL zero_waddr got v=%b wen=%b fwd=%b a=%0d d=%h exp v=1 wen=0 fwd=0 a=0 d=0",
                         mem_valid, mem_wen, fwd_en, fwd_addr, fwd_data);
    end
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    offer(1'b1, mk(32'h200, 32'h201, 1'b1, 5'd4, 4'h0)); tick();
    offer(1'b1, mk(32'h204, 32'h205, 1'b1, 5'd5, 4'h0)); tick();
    offer(1'b1, mk(32'h208, 32'h209, 1'b1, 5'd6, 4'h0));
    mem_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, '0);
    n_tests++;
    if (occupancy !== 2'd0 || mem_valid !== 1'b0 || ex_ready !== 1'b1 || fwd_en !== 1'b0) begin
      n_fail++; $display("FAIL flush got occ=%0d v=%b rdy=%b fwd=%b exp occ=0 v=0 rdy=1 fwd=0",
                         occupancy, mem_valid, ex_ready, fwd_en);
    end
    offer(1'b1, mk(32'h20C, 32'h20D, 1'b1, 5'd8, 4'h0)); tick();
    offer(1'b0, '0);
    n_tests++;
    if (mem_valid !== 1'b1 || occupancy !== 2'd1 || mem_pc !== 32'h20C) begin
      n_fail++; $display("FAIL flush_after got v=%b occ=%0d pc=%h exp v=1 occ=1 pc=20c", mem_valid, occupancy, mem_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    offer(1'b1, mk(32'h300, 32'h301, 1'b1, 5'd9, 4'h8)); tick();
    offer(1'b1, mk(32'h304, 32'h305, 1'b1, 5'd10, 4'h0));
    #2 rst = 1'b0;
    #1;
    sb.delete();
    n_tests++;
    if (mem_valid !== 1'b0 || occupancy !== 2'd0 || ex_ready !== 1'b1 || mem_pc !== 32'd0 ||
        fwd_en !== 1'b0 || fwd_is_load !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got v=%b occ=%0d rdy=%b pc=%h fwd=%b exp v=0 occ=0 rdy=1 pc=0 fwd=0",
                         mem_valid, occupancy, ex_ready, mem_pc, fwd_en);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    offer(1'b0, '0);
    n_tests++;
    if (mem_valid !== 1'b1 || mem_pc !== 32'h304 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL reset_release got v=%b pc=%h occ=%0d exp v=1 pc=304 occ=1", mem_valid, mem_pc, occupancy);
    end
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    ent_t h, y;
    int   errs = 0;
    for (int i = 0; i < 200; i++) begin
      offer($urandom_range(0, 3) != 0,
            mk(32'h1000 + 32'(4*i), $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
               4'($urandom_range(0, 15))));
      mem_ready = $urandom_range(0, 2) != 0;
      h = (sb.size() > 0) ? sb[0] : '0;
      y = (sb.size() > 0) ? sb[sb.size()-1] : '0;
      n_tests++;
      if (occupancy !== 2'(sb.size()) || ex_ready !== (sb.size() < 2) || mem_valid !== (sb.size() > 0) ||
          mem_pc !== h.pc || mem_result !== h.result || mem_funct !== h.funct || mem_wen !== h.wen ||
          mem_waddr !== h.waddr || mem_mem_op !== h.mem_op || mem_mem_wdata !== h.wdata) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL b2b_head[%0d] got occ=%0d pc=%h wen=%b op=%h exp occ=%0d pc=%h wen=%b op=%h",
                                i, occupancy, mem_pc, mem_wen, mem_mem_op, sb.size(), h.pc, h.wen, h.mem_op);
      end
      n_tests++;
      if (fwd_en !== y.wen || fwd_is_load !== y.mem_op[3] ||
          fwd_addr !== (y.wen ? y.waddr : 5'd0) || fwd_data !== (y.wen ? y.result : 32'd0)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL b2b_fwd[%0d] got en=%b a=%0d ld=%b exp en=%b a=%0d ld=%b",
                                i, fwd_en, fwd_addr, fwd_is_load, y.wen, y.waddr, y.mem_op[3]);
      end
      tick();
    end
    offer(1'b0, '0);
    mem_ready = 1'b1;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_forward();
    test_zero_waddr();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
